// File: rtl/axi_lite_slave_pkg.sv
// Shared types and helpers for the AXI4-Lite register slave.
// Optional feature macro: AXIL_SLV_WCOUNT_EN (write-commit counter register).
package axi_lite_slave_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_AW,
        W_HAVE_W,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_t;

    // Merge new data into an existing word, one byte lane per strobe bit.
    function automatic logic [31:0] apply_wstrb(input logic [31:0] old,
                                                input logic [31:0] data,
                                                input logic [3:0]  strb);
        logic [31:0] mask;
        for (int b = 0; b < 4; b++) begin
            mask[8*b +: 8] = {8{strb[b]}};
        end
        return (old & ~mask) | (data & mask);
    endfunction

endpackage

// File: rtl/axi_lite_slave_regfile.sv
// Register storage for the AXI4-Lite slave: byte-strobed write port,
// combinational read mux and index decode.
// With AXIL_SLV_WCOUNT_EN defined, index NUM_REGS is a read-only count of
// writes that landed in a register; writes there are dropped but answered OKAY.
module axi_lite_slave_regfile
    import axi_lite_slave_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_REGS   = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_we,
    input  logic [ADDR_WIDTH-3:0]          i_widx,
    input  logic [DATA_WIDTH-1:0]          i_wdata,
    input  logic [DATA_WIDTH/8-1:0]        i_wstrb,
    output logic                           o_werr,
    input  logic [ADDR_WIDTH-3:0]          i_ridx,
    output logic [DATA_WIDTH-1:0]          o_rdata,
    output logic                           o_rerr,
    output logic [NUM_REGS*DATA_WIDTH-1:0] o_reg_out
);

    localparam logic [31:0] NREG_U = 32'(NUM_REGS);

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic [31:0]           w_wsel;
    logic [31:0]           w_rsel;
    logic                  w_wr_in;

    assign w_wsel  = 32'(i_widx);
    assign w_rsel  = 32'(i_ridx);
    assign w_wr_in = (w_wsel < NREG_U);

`ifdef AXIL_SLV_WCOUNT_EN
    logic [31:0] r_wcount;

    assign o_werr = !(w_wr_in || (w_wsel == NREG_U));

    // Count only writes that actually updated a register; wraps naturally at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_wcount <= '0;
        else if (i_we && w_wr_in)
            r_wcount <= r_wcount + 32'd1;
    end
`else
    assign o_werr = !w_wr_in;
`endif

    // Byte-strobed update of the addressed register; out-of-range writes touch nothing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                r_regs[k] <= '0;
            end
        end else if (i_we) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (w_wsel == 32'(k))
                    r_regs[k] <= apply_wstrb(r_regs[k], i_wdata, i_wstrb);
            end
        end
    end

    // Read mux: unmapped indices return zero with an error flag.
    always_comb begin
        o_rdata = '0;
        o_rerr  = 1'b1;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (w_rsel == 32'(k)) begin
                o_rdata = r_regs[k];
                o_rerr  = 1'b0;
            end
        end
`ifdef AXIL_SLV_WCOUNT_EN
        if (w_rsel == NREG_U) begin
            o_rdata = r_wcount;
            o_rerr  = 1'b0;
        end
`endif
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
        assign o_reg_out[g*DATA_WIDTH +: DATA_WIDTH] = r_regs[g];
    end

endmodule

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit control registers.
// Independent write (AW/W/B) and read (AR/R) channel FSMs, one outstanding
// transaction per direction. Optional macro: AXIL_SLV_WCOUNT_EN.
module axi_lite_slave_regs
    import axi_lite_slave_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_REGS   = 4
) (
    input  logic                           ACLK,
    input  logic                           ARESET,
    input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic [2:0]                     S_AXI_AWPROT,
    input  logic                           S_AXI_AWVALID,
    output logic                           S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                           S_AXI_WVALID,
    output logic                           S_AXI_WREADY,
    output logic [1:0]                     S_AXI_BRESP,
    output logic                           S_AXI_BVALID,
    input  logic                           S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic [2:0]                     S_AXI_ARPROT,
    input  logic                           S_AXI_ARVALID,
    output logic                           S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                     S_AXI_RRESP,
    output logic                           S_AXI_RVALID,
    input  logic                           S_AXI_RREADY,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out
);

    localparam int IDX_W = ADDR_WIDTH - 2;

    wr_state_t               r_wstate;
    rd_state_t               r_rstate;
    logic [IDX_W-1:0]        r_awidx;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH/8-1:0] r_wstrb;
    logic                    r_bvalid;
    resp_t                   r_bresp;
    logic                    r_rvalid;
    resp_t                   r_rresp;
    logic [DATA_WIDTH-1:0]   r_rdata;

    logic                    w_commit;
    logic [IDX_W-1:0]        w_cidx;
    logic [DATA_WIDTH-1:0]   w_cdata;
    logic [DATA_WIDTH/8-1:0] w_cstrb;
    logic                    w_werr;
    logic [DATA_WIDTH-1:0]   w_rdata;
    logic                    w_rerr;
    logic [IDX_W-1:0]        w_aw_idx;
    logic [IDX_W-1:0]        w_ar_idx;
    logic                    w_unused;

    assign w_aw_idx = S_AXI_AWADDR[ADDR_WIDTH-1:2];
    assign w_ar_idx = S_AXI_ARADDR[ADDR_WIDTH-1:2];
    assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // Ready decoded from state, held low for the whole of reset.
    assign S_AXI_AWREADY = !ARESET && ((r_wstate == W_IDLE) || (r_wstate == W_HAVE_W));
    assign S_AXI_WREADY  = !ARESET && ((r_wstate == W_IDLE) || (r_wstate == W_HAVE_AW));
    assign S_AXI_ARREADY = !ARESET && (r_rstate == R_IDLE);
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RRESP   = r_rresp;
    assign S_AXI_RDATA   = r_rdata;

    // Pick the commit source: live channel inputs or the half latched earlier.
    always_comb begin
        w_commit = 1'b0;
        w_cidx   = r_awidx;
        w_cdata  = r_wdata;
        w_cstrb  = r_wstrb;
        case (r_wstate)
            W_IDLE: begin
                if (S_AXI_AWVALID && S_AXI_WVALID) begin
                    w_commit = 1'b1;
                    w_cidx   = w_aw_idx;
                    w_cdata  = S_AXI_WDATA;
                    w_cstrb  = S_AXI_WSTRB;
                end
            end
            W_HAVE_AW: begin
                if (S_AXI_WVALID) begin
                    w_commit = 1'b1;
                    w_cdata  = S_AXI_WDATA;
                    w_cstrb  = S_AXI_WSTRB;
                end
            end
            W_HAVE_W: begin
                if (S_AXI_AWVALID) begin
                    w_commit = 1'b1;
                    w_cidx   = w_aw_idx;
                end
            end
            default: ;
        endcase
    end

    // Write channel FSM: gather AW and W in any order, commit, then hold B until taken.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_wstate <= W_IDLE;
            r_awidx  <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
            r_bvalid <= 1'b0;
            r_bresp  <= OKAY;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (w_commit) begin
                        r_bvalid <= 1'b1;
                        r_bresp  <= w_werr ? SLVERR : OKAY;
                        r_wstate <= W_RESP;
                    end else if (S_AXI_AWVALID) begin
                        r_awidx  <= w_aw_idx;
                        r_wstate <= W_HAVE_AW;
                    end else if (S_AXI_WVALID) begin
                        r_wdata  <= S_AXI_WDATA;
                        r_wstrb  <= S_AXI_WSTRB;
                        r_wstate <= W_HAVE_W;
                    end
                end
                W_HAVE_AW, W_HAVE_W: begin
                    if (w_commit) begin
                        r_bvalid <= 1'b1;
                        r_bresp  <= w_werr ? SLVERR : OKAY;
                        r_wstate <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        r_bvalid <= 1'b0;
                        r_wstate <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    // Read channel FSM: capture data on AR, hold it until R is accepted.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_rstate <= R_IDLE;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= OKAY;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (S_AXI_ARVALID) begin
                        r_rdata  <= w_rdata;
                        r_rresp  <= w_rerr ? SLVERR : OKAY;
                        r_rvalid <= 1'b1;
                        r_rstate <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        r_rvalid <= 1'b0;
                        r_rstate <= R_IDLE;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    axi_lite_slave_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_regfile (
        .clk       (ACLK),
        .rst       (ARESET),
        .i_we      (w_commit),
        .i_widx    (w_cidx),
        .i_wdata   (w_cdata),
        .i_wstrb   (w_cstrb),
        .o_werr    (w_werr),
        .i_ridx    (w_ar_idx),
        .o_rdata   (w_rdata),
        .o_rerr    (w_rerr),
        .o_reg_out (reg_out)
    );

endmodule
